// File: rtl/ecc_pkg.sv
// Shared constants, state encoding and codeword position map for the
// 72/64 SECDED RAM controller.
package ecc_pkg;

  localparam int DATA_W = 64;
  localparam int CW_W   = 72;
  localparam int SYN_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RSP
  } state_t;

  // Codeword position of data bit i: the i-th non-power-of-two index in 3..71.
  function automatic int data_pos(input int i);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cnt++;
        if (cnt == i) pos = p;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_72_64.sv
// Combinational extended-Hamming encoder (write path) and
// decoder/corrector (read path) for 64 data bits in a 72-bit codeword.
module secded_72_64
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] enc_data,
  output logic [CW_W-1:0]   enc_cw,
  input  logic [CW_W-1:0]   dec_cw_in,
  output logic [DATA_W-1:0] dec_data,
  output logic [CW_W-1:0]   dec_cw,
  output logic              dec_sbe,
  output logic              dec_dbe
);

  logic [SYN_W-1:0] syn;
  logic             pbit;

  always_comb begin
    enc_cw = '0;
    for (int i = 0; i < DATA_W; i++) enc_cw[data_pos(i)] = enc_data[i];
    // Parity slots are still zero here, so each one only covers data positions.
    for (int k = 0; k < SYN_W; k++) begin
      for (int p = 1; p < CW_W; p++) begin
        if (((p >> k) & 1) == 1) enc_cw[1 << k] = enc_cw[1 << k] ^ enc_cw[p];
      end
    end
    enc_cw[0] = ^enc_cw[CW_W-1:1];
  end

  always_comb begin
    syn = '0;
    for (int k = 0; k < SYN_W; k++) begin
      for (int p = 1; p < CW_W; p++) begin
        if (((p >> k) & 1) == 1) syn[k] = syn[k] ^ dec_cw_in[p];
      end
    end
    pbit    = ^dec_cw_in;
    dec_cw  = dec_cw_in;
    dec_sbe = 1'b0;
    dec_dbe = 1'b0;
    if (pbit) begin
      if (syn == '0) begin
        dec_cw[0] = ~dec_cw_in[0];
        dec_sbe   = 1'b1;
      end else if (syn <= SYN_W'(CW_W - 1)) begin
        dec_cw[syn] = ~dec_cw_in[syn];
        dec_sbe     = 1'b1;
      end else begin
        dec_dbe = 1'b1;
      end
    end else if (syn != '0) begin
      dec_dbe = 1'b1;
    end
    dec_data = '0;
    for (int i = 0; i < DATA_W; i++) dec_data[i] = dec_cw[data_pos(i)];
  end

endmodule

// File: rtl/ecc_ram_ctrl_4x64.sv
// Request/response controller for a 4x72 DFF RAM: SECDED encode on write,
// decode/correct on read, optional scrub write-back and saturating error counters.
module ecc_ram_ctrl_4x64
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_scrub_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_sbe,
  output logic              rsp_dbe,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count,
  output logic [1:0]        ram_address,
  output logic              ram_en_n,
  output logic              ram_wr,
  output logic [CW_W-1:0]   ram_wdata,
  input  logic [CW_W-1:0]   ram_rdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  state_t            state, state_nx;
  logic [CW_W-1:0]   enc_cw, dec_cw;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sbe, dec_dbe;
  logic [1:0]        rd_addr_p0;
  logic [CW_W-1:0]   scrub_cw_p1;
  logic              scrub_pend;

  secded_72_64 u_secded (
    .enc_data  (req_wdata),
    .enc_cw    (enc_cw),
    .dec_cw_in (ram_rdata),
    .dec_data  (dec_data),
    .dec_cw    (dec_cw),
    .dec_sbe   (dec_sbe),
    .dec_dbe   (dec_dbe)
  );

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    ram_en_n    = 1'b1;
    ram_wr      = 1'b1;
    ram_address = req_addr;
    ram_wdata   = enc_cw;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        ram_en_n  = !req_valid;
        ram_wr    = !req_we;
        if (req_valid && !req_we) state_nx = RD_WAIT;
      end
      RD_WAIT: state_nx = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (scrub_pend) begin
          ram_en_n    = 1'b0;
          ram_wr      = 1'b0;
          ram_address = rd_addr_p0;
          ram_wdata   = scrub_cw_p1;
        end
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Keep the RAM untouched while reset is held, whatever the inputs do.
    if (!rst_n) ram_en_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      scrub_pend <= 1'b0;
      rsp_rdata  <= '0;
      rsp_sbe    <= 1'b0;
      rsp_dbe    <= 1'b0;
      sbe_count  <= '0;
      dbe_count  <= '0;
    end else begin
      state <= state_nx;
      if (state == RSP) scrub_pend <= 1'b0;
      // p1: decoded read data registered into the response stage
      if (state == RD_WAIT) begin
        rsp_rdata  <= dec_data;
        rsp_sbe    <= dec_sbe;
        rsp_dbe    <= dec_dbe;
        scrub_pend <= dec_sbe && cfg_scrub_en;
        if (dec_sbe) sbe_count <= sat_inc(sbe_count);
        if (dec_dbe) dbe_count <= sat_inc(dbe_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && !req_we) rd_addr_p0 <= req_addr;
    if (state == RD_WAIT) scrub_cw_p1 <= dec_cw;
  end

endmodule

// File: doc/ecc_ram_ctrl_4x64.md
Name: ecc_ram_ctrl_4x64

Overview:
SECDED front-end and request controller that sits directly upstream of the 4-entry x 72-bit DFF RAM macro (ports: address[1:0], en_n, wr with 0=write/1=read, wdata[71:0], registered rdata[71:0]).
- Accepts 64-bit read/write requests over valid/ready and encodes each write into a 72-bit extended-Hamming codeword.
- Decodes and corrects read data, then returns it on a valid/ready response channel.
- Optionally scrubs corrected single-bit errors back into the RAM, and keeps saturating error counters.

Parameters:
CNT_W, 16, width of the sbe_count and dbe_count saturating error counters (minimum 2).

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst_n  in  1  synchronous active-low reset (sampled on rising clk)
cfg_scrub_en  in  1  1 = write the corrected codeword back after a single-bit error
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  2  entry index 0..3
req_wdata  in  64  write data
rsp_valid  out  1  read response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  64  corrected read data
rsp_sbe  out  1  single-bit error detected and corrected
rsp_dbe  out  1  uncorrectable error
sbe_count  out  CNT_W  saturating single-bit error count
dbe_count  out  CNT_W  saturating double-bit error count
ram_address  out  2  to RAM address
ram_en_n  out  1  to RAM en_n (active low)
ram_wr  out  1  to RAM wr (0 = write, 1 = read)
ram_wdata  out  72  to RAM wdata
ram_rdata  in  72  from RAM rdata; valid the cycle after a read is issued

Behaviour:
- Codeword layout: bit i of ram_wdata/ram_rdata is codeword position i.
  - Positions 1,2,4,8,16,32,64 hold Hamming parity bits.
  - The remaining 64 positions in 3..71 hold data bits 0..63 in ascending order.
  - Parity bit at position p gives even parity over all positions 1..71 whose index has bit p set.
  - Bit 0 gives even parity over positions 1..71.
- Decode:
  - syndrome S is 7 bits; P is the overall parity over bits 0..71.
  - S=0, P=0: no error.
  - P=1 and S in 1..71: flip position S, sbe=1.
  - P=1 and S=0: bit 0 in error, data intact, sbe=1.
  - P=0 and S!=0: dbe=1, data returned uncorrected.
  - P=1 and S>71: dbe=1.
- FSM states: IDLE, RD_WAIT, RSP. Reset state is IDLE.
- IDLE:
  - req_ready=1. RAM ports are driven combinationally from the request: ram_en_n = !req_valid, ram_wr = !req_we, ram_address = req_addr, ram_wdata = encode(req_wdata).
  - An accepted write completes at that edge, produces no response, and the block stays in IDLE. Back-to-back writes run at 1 per cycle.
  - An accepted read goes to RD_WAIT.
- RD_WAIT:
  - req_ready=0, ram_en_n=1.
  - Decode ram_rdata and register rsp_rdata/rsp_sbe/rsp_dbe, plus the corrected codeword and address for scrub.
  - Update counters: +1 on sbe or dbe, saturating at all-ones.
  - Set scrub_pend = sbe && cfg_scrub_en. Go to RSP.
  - Read latency: request accept at cycle T, rsp_valid=1 in T+2.
- RSP:
  - rsp_valid=1. Response outputs are held stable until rsp_ready. req_ready=0.
  - If scrub_pend: in the first RSP cycle drive ram_en_n=0, ram_wr=0, stored address, stored corrected codeword, then clear scrub_pend. Otherwise ram_en_n=1.
  - On rsp_ready, go to IDLE. A request cannot be accepted in the same cycle.
- ram_en_n is 1 whenever no access is being issued.
- Reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_sbe=0, rsp_dbe=0, counters 0, scrub_pend=0, ram_en_n=1.
- Reset mid-operation: a pending read or scrub is dropped with no response, RAM contents are untouched, and the RAM write-enable is never asserted during reset.
- RAM entries are uninitialised; reading an unwritten entry is not a supported use.

Decomposition:
- Shared package ecc_pkg holds:
  - constants DATA_W=64, CW_W=72, SYN_W=7
  - the data-to-position map as a constant function
  - state enum typedef for IDLE/RD_WAIT/RSP
- One combinational sub-module secded_72_64 holds the encoder plus decoder (outputs: corrected data, corrected codeword, sbe, dbe). It is instantiated once for the write path and once for the read path, or split into enc and dec functions.
- The bench instantiates the real RAM macro behind this block.

Test Plan:
1. Write addr 1 = 0x0123456789ABCDEF, then read addr 1 → rsp_valid exactly 2 cycles after accept, rsp_rdata = 0x0123456789ABCDEF, sbe=0, dbe=0, counters stay 0.
2. Write addr 2 = 0xFFFF0000AAAA5555, backdoor-flip codeword bit 3, read with cfg_scrub_en=1 → rsp_rdata = 0xFFFF0000AAAA5555, sbe=1, sbe_count=1, scrub write observed on ram_en_n/ram_wr; a re-read gives sbe=0.
3. Same setup but flip bits 3 and 5 → dbe=1, sbe=0, dbe_count=1, no scrub write issued.
4. Hold rsp_ready=0 for 5 cycles during RSP → rsp_* stable, req_ready=0, ram_en_n=1 after the scrub cycle; release → IDLE next cycle.
5. Assert rst_n=0 for 1 cycle while in RD_WAIT → rsp_valid never rises, state IDLE, counters 0, previously written data readable intact.
6. CNT_W=2, inject 5 single-bit errors → sbe_count saturates at 3. Also flip bit 0 only → sbe=1, data unchanged.
